round_key_store: RTL and testbench

Sequential AES-128 key-schedule unit that accepts a 128-bit cipher key, iterates the one-round combinational key-expansion stage (round constants 1..10) one round per clock, and stores all 11 round keys in registers. It sits directly downstream of the key-expansion stage and upstream of the pipelined cipher datapath. It presents the full round-key set as a flat parallel bus, so every pipeline round stage taps its own key.

---
 rtl/round_key_store.sv | 118 +++++++++++
 tb/tb_round_key_store.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/round_key_store.sv
// round_key_store: AES-128 key schedule, one expansion round per clock, holds all 11 round keys
// Ports: clk; rst (sync, active-high); key_in/key_valid/key_ready accept a cipher key;
//   busy while expanding; done pulses as rk10 lands; keys_valid flags a complete set;
//   round_keys carries round key r at [128*r +: 128], rk0 = cipher key.
// Option KEYSTORE_DOUBLE_BUF_EN: expand into a shadow bank and swap it onto round_keys on done.
module round_key_store (
  input  logic          clk,
  input  logic          rst,
  input  logic [127:0]  key_in,
  input  logic          key_valid,
  output logic          key_ready,
  output logic          busy,
  output logic          done,
  output logic          keys_valid,
  output logic [1407:0] round_keys
);
`ifdef KEYSTORE_DOUBLE_BUF_EN
  // rk10 goes straight into the active bank on the swap edge, so the shadow holds rk0..rk9
  localparam int NS = 10;
`else
  localparam int NS = 11;
`endif
  localparam logic [127:0] RCON = {48'h0, 80'h36_1b_80_40_20_10_08_04_02_01};
  typedef enum logic {IDLE, EXPAND} state_t;
  state_t state_q, state_d;
  logic [3:0] round_q, round_d, ri;
  logic [127:0] wk_q, wk_d, nk;
  logic [NS-1:0][127:0] rk_q, rk_d;
  logic kv_q, kv_d, busy_q, busy_d, done_q, done_d, accept, last;
`ifdef KEYSTORE_DOUBLE_BUF_EN
  logic [10:0][127:0] act_q, act_d;
`endif
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // S-box as GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b, r;
    b = x;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      b = gmul(b, b);
      r = gmul(r, b);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  assign key_ready = state_q == IDLE && !rst;
  assign busy = busy_q;
  assign done = done_q;
  assign keys_valid = kv_q;
  always_comb begin
    accept = key_valid && key_ready;
    last = state_q == EXPAND && round_q == 4'd10;
    ri = round_q - 4'd1;
    nk = expand(wk_q, RCON[{ri, 3'b000} +: 8]);
    state_d = accept ? EXPAND : last ? IDLE : state_q;
    round_d = accept ? 4'd1 : last ? 4'd0 : state_q == EXPAND ? round_q + 4'd1 : round_q;
    wk_d = accept ? key_in : state_q == EXPAND ? nk : wk_q;
    rk_d = rk_q;
    rk_d[0] = accept ? key_in : rk_q[0];
    for (int r = 1; r < NS; r++)
      rk_d[r] = state_q == EXPAND && round_q == 4'(r) ? nk : rk_q[r];
    busy_d = state_d == EXPAND;
    done_d = last;
`ifdef KEYSTORE_DOUBLE_BUF_EN
    kv_d = last || kv_q;
    act_d = last ? {nk, rk_q} : act_q;
`else
    kv_d = !accept && (last || kv_q);
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= '0;
      wk_q <= '0;
      rk_q <= '0;
      kv_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef KEYSTORE_DOUBLE_BUF_EN
      act_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      wk_q <= wk_d;
      rk_q <= rk_d;
      kv_q <= kv_d;
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef KEYSTORE_DOUBLE_BUF_EN
      act_q <= act_d;
`endif
    end
  end
`ifdef KEYSTORE_DOUBLE_BUF_EN
  assign round_keys = act_q;
`else
  assign round_keys = rk_q;
`endif
endmodule

// File: tb/tb_round_key_store.sv
// tb_round_key_store: scoreboard bench for round_key_store against a word-level FIPS-197 key expansion model
module tb_round_key_store;
  typedef logic [10:0][127:0] rks_t;
  typedef struct {
    rks_t rk;
    int   acc;
    bit   fips;
  } exp_t;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  logic clk, rst, key_valid, key_ready, busy, done, keys_valid;
  logic [127:0] key_in;
  logic [1407:0] rk_o;
  logic [7:0] sb [256];
  exp_t q[$];
  rks_t cur;
  bit have, busy_e, done_e;
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  round_key_store dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .busy(busy), .done(done), .keys_valid(keys_valid), .round_keys(rk_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // polynomial product reduced modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction
  function automatic logic [7:0] affine(input logic [7:0] b);
    logic [7:0] c, s;
    c = 8'h63;
    for (int i = 0; i < 8; i++)
      s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
    return s;
  endfunction
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = affine(inv);
    end
  endtask
  function automatic rks_t model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    rks_t res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++) res[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    return res;
  endfunction
  task automatic chk(input string nm, input int idx, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] cycle %0d: got %h expected %h", nm, idx, cyc, got, exp);
    end
  endtask
  task automatic chkb(input string nm, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      chkb("key_ready_in_rst", key_ready, 1'b0);
      q.delete();
      cur = '0;
      have = 1'b0;
    end else begin
      busy_e = q.size() != 0 && cyc < q[0].acc + 10;
      done_e = q.size() != 0 && cyc == q[0].acc + 10;
      chkb("busy", busy, busy_e);
      chkb("key_ready", key_ready, !busy_e);
      chkb("done", done, done_e);
      if (done_e) begin
        cur = q[0].rk;
        have = 1'b1;
        if (q[0].fips) begin
          chk("fips_rk", 1, rk_o[128 +: 128], FIPS_RK1);
          chk("fips_rk", 10, rk_o[1280 +: 128], FIPS_RK10);
        end
        q.delete(0);
      end
`ifdef KEYSTORE_DOUBLE_BUF_EN
      chkb("keys_valid", keys_valid, have);
      for (int r = 0; r < 11; r++) chk("round_key", r, rk_o[128 * r +: 128], cur[r]);
`else
      chkb("keys_valid", keys_valid, have && !busy_e);
      if (!busy_e)
        for (int r = 0; r < 11; r++) chk("round_key", r, rk_o[128 * r +: 128], cur[r]);
      else
        for (int r = 0; r <= cyc - q[0].acc; r++) chk("partial_key", r, rk_o[128 * r +: 128], q[0].rk[r]);
`endif
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // drives one key in an idle cycle; with hold, key_valid stays high with junk keys for the 10 busy cycles
  task automatic send(input logic [127:0] k, input bit f, input bit hold);
    exp_t e;
    key_in = k;
    key_valid = 1'b1;
    step();
    e.rk = model(k);
    e.acc = cyc;
    e.fips = f;
    q.push_back(e);
    if (hold) repeat (10) begin
      key_in = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    key_valid = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask
  initial begin
    bit h;
    rst = 1'b1;
    key_valid = 1'b0;
    key_in = '0;
    build_sbox();
    step();
    key_valid = 1'b1;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    step();
    rst = 1'b0;
    key_valid = 1'b0;
    repeat (2) step();
    send(FIPS_KEY, 1'b1, 1'b0);
    repeat (12) step();
    send(128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b0);
    repeat (10) step();
    send(FIPS_KEY, 1'b1, 1'b0);
    repeat (11) step();
    send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1);
    step();
    send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    repeat (4) step();
    rst = 1'b1;
    key_valid = 1'b1;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    step();
    rst = 1'b0;
    key_valid = 1'b0;
    step();
    send(FIPS_KEY, 1'b1, 1'b0);
    repeat (10) step();
    for (int n = 0; n < 30; n++) begin
      h = $urandom_range(0, 3) == 0;
      send({$urandom, $urandom, $urandom, $urandom}, 1'b0, h);
      if (!h) repeat (10) step();
      repeat ($urandom_range(0, 3)) step();
    end
    repeat (13) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
